alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Multi-cycle controller sequencing a register-file / ALU datapath for a
//   small instruction set (MOV imm, MOV reg, ADD, AND, CMP, MVN).  One
//   instruction is accepted at a time with a valid/ready handshake.  Each
//   instruction is walked through GET_A / GET_B / EXEC / EXEC_S / WRITE /
//   WRITE_IMM, or rejected through ERR.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   instr_valid  instruction offered this cycle
//   instr[15:0]  {opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0]}
//   instr_ready  controller idle, can accept an instruction
//   readnum      register-file read index
//   writenum     register-file write index
//   write        register-file write enable
//   loada/b/c/s  A / B / C / status register load enables
//   asel         force ALU input A to zero
//   vsel         write-back source (0 = C register, 1 = sximm8)
//   ALUop        ALU operation (00 add, 01 sub, 10 and, 11 not B)
//   shift        shifter control for the B path
//   sximm8       sign-extended imm8 of the latched instruction
//   done         one-cycle pulse, instruction complete
//   err          one-cycle pulse, illegal instruction rejected

module alu_seq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    EXEC,
    EXEC_S,
    WRITE,
    WRITE_IMM,
    ERR
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] ir;
  logic [15:0] src;
  logic        accept;

  // First state after accepting an instruction, keyed on {opcode, op}.
  function automatic state_t first_state(input logic [4:0] opc);
    case (opc)
      5'b110_10: first_state = WRITE_IMM;
      5'b110_00: first_state = GET_B;
      5'b101_00: first_state = GET_A;
      5'b101_10: first_state = GET_A;
      5'b101_01: first_state = GET_A;
      5'b101_11: first_state = GET_B;
      default:   first_state = ERR;
    endcase
  endfunction

  // Shift field applies to every register-operand instruction; MOV imm and
  // rejected encodings leave the shifter idle.
  function automatic logic [1:0] shift_of(input logic [15:0] ins);
    if ((ins[15:11] == 5'b110_00) || (ins[15:13] == 3'b101))
      shift_of = ins[4:3];
    else
      shift_of = 2'b00;
  endfunction

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign accept = (state == IDLE) && instr_valid;

  // Fields are taken from the live input while idle (the accept cycle) and
  // from the latched copy afterwards, so the registered outputs for the
  // next state are valid from the very first cycle after accept.
  always_comb begin
    src = (state == IDLE) ? instr : ir;
    nxt = state;
    case (state)
      IDLE:    nxt = instr_valid ? first_state(src[15:11]) : IDLE;
      GET_A:   nxt = GET_B;
      GET_B:   nxt = (src[12:11] == 2'b01 && src[15:13] == 3'b101) ? EXEC_S : EXEC;
      EXEC:    nxt = WRITE;
      default: nxt = IDLE;
    endcase
  end

  // Single state register; every control output is registered and set
  // according to the state being entered, so all strobes default to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ir          <= 16'h0000;
      instr_ready <= 1'b1;
      readnum     <= 3'd0;
      writenum    <= 3'd0;
      write       <= 1'b0;
      loada       <= 1'b0;
      loadb       <= 1'b0;
      loadc       <= 1'b0;
      loads       <= 1'b0;
      asel        <= 1'b0;
      vsel        <= 1'b0;
      ALUop       <= 2'b00;
      shift       <= 2'b00;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= nxt;
      instr_ready <= 1'b0;
      readnum     <= 3'd0;
      writenum    <= 3'd0;
      write       <= 1'b0;
      loada       <= 1'b0;
      loadb       <= 1'b0;
      loadc       <= 1'b0;
      loads       <= 1'b0;
      asel        <= 1'b0;
      vsel        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;

      if (accept) begin
        ir    <= src;
        ALUop <= (src[15:13] == 3'b101) ? src[12:11] : 2'b00;
        shift <= shift_of(src);
      end

      case (nxt)
        IDLE: instr_ready <= 1'b1;
        GET_A: begin
          readnum <= src[10:8];
          loada   <= 1'b1;
        end
        GET_B: begin
          readnum <= src[2:0];
          loadb   <= 1'b1;
        end
        EXEC: begin
          loadc <= 1'b1;
          // MOV reg passes B straight through by adding it to a zero A.
          asel  <= (src[15:11] == 5'b110_00);
        end
        EXEC_S: begin
          loads <= 1'b1;
          done  <= 1'b1;
        end
        WRITE: begin
          write    <= 1'b1;
          writenum <= src[7:5];
          done     <= 1'b1;
        end
        WRITE_IMM: begin
          write    <= 1'b1;
          writenum <= src[10:8];
          vsel     <= 1'b1;
          done     <= 1'b1;
        end
        ERR: err <= 1'b1;
        default: instr_ready <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//   Directed scoreboard bench for alu_seq_ctrl.  Each instruction's expected
//   per-cycle control trace is pushed into a queue before it is offered; a
//   monitor pops one entry for every busy cycle the controller presents and
//   compares the full control vector.  Idle cycles must show all strobes low.

module tb_alu_seq_ctrl;

  logic        clk;
  logic        resetN;
  logic        instrValid;
  logic [15:0] instr;
  logic        instrReady;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        vsel;
  logic [1:0]  aluOp;
  logic [1:0]  shift;
  logic [15:0] sximm8;
  logic        done;
  logic        err;

  // Snapshot layout: {readnum, writenum, enables[6:0], ALUop, shift, sximm8, done, err}
  // enables = {write, loada, loadb, loadc, loads, asel, vsel}
  typedef logic [34:0] snap_t;

  localparam logic [6:0] EN_WR = 7'b1000000;
  localparam logic [6:0] EN_LA = 7'b0100000;
  localparam logic [6:0] EN_LB = 7'b0010000;
  localparam logic [6:0] EN_LC = 7'b0001000;
  localparam logic [6:0] EN_LS = 7'b0000100;
  localparam logic [6:0] EN_AS = 7'b0000010;
  localparam logic [6:0] EN_VS = 7'b0000001;

  snap_t expQ[$];
  int    checks   = 0;
  int    failures = 0;

  alu_seq_ctrl dut (
    .clk        (clk),
    .reset_n    (resetN),
    .instr_valid(instrValid),
    .instr      (instr),
    .instr_ready(instrReady),
    .readnum    (readnum),
    .writenum   (writenum),
    .write      (write),
    .loada      (loada),
    .loadb      (loadb),
    .loadc      (loadc),
    .loads      (loads),
    .asel       (asel),
    .vsel       (vsel),
    .ALUop      (aluOp),
    .shift      (shift),
    .sximm8     (sximm8),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [2:0] rn, input logic [2:0] wn,
                               input logic [6:0] en, input logic [1:0] aop,
                               input logic [1:0] sh, input logic [15:0] imm,
                               input logic dn, input logic er);
    mk = {rn, wn, en, aop, sh, imm, dn, er};
  endfunction

  function automatic snap_t actualSnap();
    actualSnap = {readnum, writenum, write, loada, loadb, loadc, loads, asel,
                  vsel, aluOp, shift, sximm8, done, err};
  endfunction

  task automatic checkVal(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor comparison for one busy cycle.
  task automatic checkOutput();
    snap_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_busy_cycle: got %h expected none", actualSnap());
    end else begin
      e = expQ.pop_front();
      checkVal("busy_cycle", actualSnap(), e);
    end
  endtask

  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      if (instrReady === 1'b0)
        checkOutput();
      else
        checkVal("idle_strobes",
                 {28'd0, readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel, done, err},
                 35'd0);
    end
  end

  // Offer an instruction once ready; afterwards drive busyIns on instr and
  // keep instr_valid high for holdBusy more edges while the DUT is busy.
  task automatic applyStimulus(input logic [15:0] ins, input int holdBusy, input logic [15:0] busyIns);
    int n = 0;
    while (instrReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (instrReady !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout: got %b expected 1", instrReady);
    end
    instr      = ins;
    instrValid = 1'b1;
    @(posedge clk);
    #1;
    instr      = busyIns;
    instrValid = (holdBusy > 0);
    repeat (holdBusy) @(posedge clk);
    #1;
    instrValid = 1'b0;
  endtask

  initial begin
    int n;
    resetN     = 1'b1;
    instrValid = 1'b0;
    instr      = 16'h0000;
    #1;
    resetN = 1'b0;
    #1;
    checkVal("reset_ready", {34'd0, instrReady}, 35'd1);
    checkVal("reset_outputs", actualSnap(), 35'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;

    // MOV R3,#-2
    expQ.push_back(mk(3'd0, 3'd3, EN_WR | EN_VS, 2'b00, 2'b00, 16'hFFFE, 1'b1, 1'b0));
    applyStimulus(16'hD3FE, 0, 16'h0000);

    // ADD R2,R1,R0 ; instr scrambled after accept must not matter
    expQ.push_back(mk(3'd1, 3'd0, EN_LA, 2'b00, 2'b00, 16'h0040, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd0, EN_LB, 2'b00, 2'b00, 16'h0040, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd0, EN_LC, 2'b00, 2'b00, 16'h0040, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd2, EN_WR, 2'b00, 2'b00, 16'h0040, 1'b1, 1'b0));
    applyStimulus(16'hA140, 0, 16'hFFFF);

    // CMP R5,R6
    expQ.push_back(mk(3'd5, 3'd0, EN_LA, 2'b01, 2'b00, 16'h0006, 1'b0, 1'b0));
    expQ.push_back(mk(3'd6, 3'd0, EN_LB, 2'b01, 2'b00, 16'h0006, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd0, EN_LS, 2'b01, 2'b00, 16'h0006, 1'b1, 1'b0));
    applyStimulus(16'hAD06, 0, 16'h0000);

    // Illegal opcode 111, with a MOV imm offered while busy (ignored)
    expQ.push_back(mk(3'd0, 3'd0, 7'd0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1));
    applyStimulus(16'hE000, 1, 16'hD3FE);

    // MOV R4,R7 with sh=01
    expQ.push_back(mk(3'd7, 3'd0, EN_LB, 2'b00, 2'b01, 16'hFF8F, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd0, EN_LC | EN_AS, 2'b00, 2'b01, 16'hFF8F, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd4, EN_WR, 2'b00, 2'b01, 16'hFF8F, 1'b1, 1'b0));
    applyStimulus(16'hC08F, 0, 16'h0000);

    // AND R6,R3,R1 sh=10, an illegal instr held valid through all busy edges
    expQ.push_back(mk(3'd3, 3'd0, EN_LA, 2'b10, 2'b10, 16'hFFD1, 1'b0, 1'b0));
    expQ.push_back(mk(3'd1, 3'd0, EN_LB, 2'b10, 2'b10, 16'hFFD1, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd0, EN_LC, 2'b10, 2'b10, 16'hFFD1, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd6, EN_WR, 2'b10, 2'b10, 16'hFFD1, 1'b1, 1'b0));
    applyStimulus(16'hB3D1, 4, 16'hE000);

    // Illegal MOV variant op=01
    expQ.push_back(mk(3'd0, 3'd0, 7'd0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1));
    applyStimulus(16'hC800, 0, 16'h0000);

    // MOV R7,#5
    expQ.push_back(mk(3'd0, 3'd7, EN_WR | EN_VS, 2'b00, 2'b00, 16'h0005, 1'b1, 1'b0));
    applyStimulus(16'hD705, 0, 16'h0000);

    // ADD aborted by reset during EXEC
    expQ.push_back(mk(3'd1, 3'd0, EN_LA, 2'b00, 2'b00, 16'h0040, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd0, EN_LB, 2'b00, 2'b00, 16'h0040, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd0, EN_LC, 2'b00, 2'b00, 16'h0040, 1'b0, 1'b0));
    applyStimulus(16'hA140, 0, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    checkVal("midop_reset_ready", {34'd0, instrReady}, 35'd1);
    checkVal("midop_reset_outputs", actualSnap(), 35'd0);
    @(posedge clk);
    #1;
    checkVal("reset_hold_outputs", actualSnap(), 35'd0);
    @(negedge clk);
    resetN = 1'b1;

    // MVN R1,R2 right after reset release
    expQ.push_back(mk(3'd2, 3'd0, EN_LB, 2'b11, 2'b00, 16'h0022, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd0, EN_LC, 2'b11, 2'b00, 16'h0022, 1'b0, 1'b0));
    expQ.push_back(mk(3'd0, 3'd1, EN_WR, 2'b11, 2'b00, 16'h0022, 1'b1, 1'b0));
    applyStimulus(16'hB822, 0, 16'h0000);

    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkVal("scoreboard_drained", {3'd0, 32'(expQ.size())}, 35'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
